// File: rtl/rr_stream_mux.sv
// rr_stream_mux
//   N-to-1 valid/ready stream multiplexer with a single registered output
//   stage. Arbitration is round-robin (RR_MODE=1) or fixed priority with the
//   lowest index winning (RR_MODE=0). The winning word is registered together
//   with the index of the channel that supplied it.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   flush      synchronous drop of the output stage
//   in_valid   per-channel valid, bit i = channel i
//   in_data    packed channel data, channel i at [i*BITWIDTH +: BITWIDTH]
//   in_ready   per-channel accept, at most one bit high
//   out_valid  output stage holds a word
//   out_data   registered winning data
//   out_sel    index of the channel that supplied out_data
//   out_ready  consumer accepts the word
module rr_stream_mux #(
    parameter int BITWIDTH = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int RR_MODE  = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*BITWIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]          in_ready,
    output logic                         out_valid,
    output logic [BITWIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]             out_sel,
    input  logic                         out_ready
);

    logic                r_out_valid;
    logic [BITWIDTH-1:0] r_out_data;
    logic [SEL_W-1:0]    r_out_sel;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_load;
    logic                w_found;
    logic [SEL_W-1:0]    w_winner;
    logic [SEL_W-1:0]    w_scan_base;
    logic [BITWIDTH-1:0] w_win_data;

    // Channel visited at step k of a scan that starts at base, modulo CHANNELS.
    function automatic int scan_idx(input logic [SEL_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= CHANNELS) s = s - CHANNELS;
        return s;
    endfunction

    // The output stage can take a new word when it is empty or being drained
    // this cycle; out_ready therefore reaches in_ready combinationally.
    assign w_load = !flush && (!r_out_valid || out_ready);

    // Fixed priority is a round-robin scan that always starts at channel 0.
    assign w_scan_base = (RR_MODE != 0) ? r_rr_ptr : '0;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned, which would otherwise infer a latch.
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!w_found && in_valid[scan_idx(w_scan_base, k)]) begin
                w_found  = 1'b1;
                w_winner = SEL_W'(scan_idx(w_scan_base, k));
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        in_ready   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (SEL_W'(k) == w_winner) begin
                w_win_data  = in_data[k*BITWIDTH +: BITWIDTH];
                // reset_n gating keeps every in_ready low during reset.
                in_ready[k] = reset_n && w_load && w_found;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: data and sel are reset too, so the output is a known zero
            // after reset rather than whatever the flops powered up with.
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_win_data;
                r_out_sel   <= w_winner;
                if (RR_MODE != 0) begin
                    r_rr_ptr <= (int'(w_winner) == CHANNELS - 1) ? '0 : w_winner + 1'b1;
                end
            end else begin
                // Drained with nothing to replace it (or already empty).
                r_out_valid <= 1'b0;
            end
        end else if (flush) begin
            // Drop the word; data/sel keep their stale values.
            r_out_valid <= 1'b0;
        end
        // Stall (out_valid && !out_ready): everything holds.
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux
//   Directed bench for rr_stream_mux. A round-robin instance is driven with
//   hand-computed vectors; each expected output word is queued when its
//   transfer is set up and a negedge monitor compares and retires entries as
//   the DUT presents them. A fixed-priority instance is checked directly.
module tb_rr_stream_mux;

    localparam int BW = 32;
    localparam int CH = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [SW-1:0] sel;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic [CH-1:0]    in_valid;
    logic [CH*BW-1:0] in_data;
    logic [CH-1:0]    in_ready;
    logic             out_valid;
    logic [BW-1:0]    out_data;
    logic [SW-1:0]    out_sel;
    logic             out_ready;

    logic             fp_flush;
    logic [CH-1:0]    fp_in_valid;
    logic [CH-1:0]    fp_in_ready;
    logic             fp_out_valid;
    logic [BW-1:0]    fp_out_data;
    logic [SW-1:0]    fp_out_sel;
    logic             fp_out_ready;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    rr_stream_mux #(.BITWIDTH(BW), .CHANNELS(CH), .SEL_W(SW), .RR_MODE(1)) u_rr (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    rr_stream_mux #(.BITWIDTH(BW), .CHANNELS(CH), .SEL_W(SW), .RR_MODE(0)) u_fp (
        .clk(clk), .reset_n(reset_n), .flush(fp_flush),
        .in_valid(fp_in_valid), .in_data(in_data), .in_ready(fp_in_ready),
        .out_valid(fp_out_valid), .out_data(fp_out_data), .out_sel(fp_out_sel),
        .out_ready(fp_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [BW-1:0] val);
        in_data[ch*BW +: BW] = val;
    endtask

    task automatic expect_word(input logic [BW-1:0] d, input logic [SW-1:0] s);
        exp_t e;
        e.data = d;
        e.sel  = s;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the presented word against the queue head; retire it
    // when the next edge consumes it (out_ready) or discards it (flush).
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got data %0h sel %0d, expected no word", out_data, out_sel);
            end else begin
                check("mon_data", 64'(out_data), 64'(sb_q[0].data));
                check("mon_sel", 64'(out_sel), 64'(sb_q[0].sel));
                if (out_ready || flush) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b1;
        in_valid     = CH'($urandom);
        in_data      = {$urandom, $urandom, $urandom, $urandom};
        fp_flush     = 1'b0;
        fp_in_valid  = '0;
        fp_out_ready = 1'b1;

        // Reset state, including across clock edges with random inputs.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sel", 64'(out_sel), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);

        // Release, then channel 2 alone.
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < CH; i++) set_ch(i, 32'hCAFE0000 + 32'(i));
        in_valid = 4'b0100;
        #1 check("first_ready", 64'(in_ready), 64'b0100);
        expect_word(32'hCAFE0002, 2'd2);
        cycle();
        check("first_latency", 64'(out_valid), 64'd1);

        // Wrap and skip: pointer is 3, only channel 0 valid.
        in_valid = 4'b0001;
        #1 check("wrap_ready", 64'(in_ready), 64'b0001);
        expect_word(32'hCAFE0000, 2'd0);
        cycle();
        // Pointer is now 1: channel 3 must beat channel 0.
        in_valid = 4'b1001;
        #1 check("ptr_after_wrap", 64'(in_ready), 64'b1000);
        expect_word(32'hCAFE0003, 2'd3);
        cycle();

        // Fairness: all valid, pointer back at 0.
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check("rr_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
            check("rr_onehot", 64'($onehot(in_ready)), 64'd1);
            expect_word(32'hCAFE0000 + 32'(k % 4), SW'(k % 4));
            cycle();
        end

        // Backpressure: load 0x11 from channel 0 (pointer 0 -> 1).
        set_ch(0, 32'h11);
        in_valid = 4'b0001;
        #1 check("bp_load_ready", 64'(in_ready), 64'b0001);
        expect_word(32'h11, 2'd0);
        cycle();
        out_ready = 1'b0;
        set_ch(0, 32'h22);
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_stall_ready", 64'(in_ready), 64'd0);
            cycle();
            check("bp_hold_data", 64'(out_data), 64'h11);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 64'(in_ready), 64'b0001);
        expect_word(32'h22, 2'd0);
        cycle();
        check("bp_no_bubble_valid", 64'(out_valid), 64'd1);
        check("bp_no_bubble_data", 64'(out_data), 64'h22);

        // Flush while holding 0x22, channel 1 waiting.
        set_ch(1, 32'hF1);
        in_valid = 4'b0010;
        flush    = 1'b1;
        #1 check("flush_ready", 64'(in_ready), 64'd0);
        cycle();
        check("flush_drop", 64'(out_valid), 64'd0);
        flush = 1'b0;
        #1 check("post_flush_ready", 64'(in_ready), 64'b0010);
        expect_word(32'hF1, 2'd1);
        cycle();
        check("post_flush_valid", 64'(out_valid), 64'd1);
        check("post_flush_sel", 64'(out_sel), 64'd1);
        in_valid = '0;

        // Fixed priority instance.
        fp_in_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            #1 check("fp_ready", 64'(fp_in_ready), 64'b0010);
            cycle();
            check("fp_sel", 64'(fp_out_sel), 64'd1);
            check("fp_valid", 64'(fp_out_valid), 64'd1);
        end
        fp_in_valid = 4'b0011;
        #1 check("fp_lowest", 64'(fp_in_ready), 64'b0001);
        fp_in_valid = '0;

        repeat (3) cycle();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
